// File: rtl/bullcow_game_core_param.sv
// Bulls-and-Cows game engine for N players with D-digit codes.
// Players enter secrets in turn, then each one guesses the next player's secret.
module bullcow_game_core_param #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_W     = 4,
    parameter int DIGIT_MAX   = 9,
    parameter int POINTS_W    = 8,
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int CW = $clog2(NUM_DIGITS + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enter,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   SW,
    output logic [2:0]                      game_state,
    output logic [PW-1:0]                   active_player,
    output logic [CW-1:0]                   bull_count,
    output logic [CW-1:0]                   cow_count,
    output logic                            guess_confirmed,
    output logic                            input_error,
    output logic [7:0]                      attempt_count,
    output logic [NUM_PLAYERS*POINTS_W-1:0] points
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
    localparam logic [POINTS_W-1:0] POINTS_MAX = '1;

    typedef enum logic [2:0] {
        SETUP = 3'd0,
        GUESS = 3'd1,
        CHECK = 3'd2,
        WIN   = 3'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                enter_q;
    logic                enter_event;
    logic                sw_valid;
    logic [CODE_W-1:0]   guess;
    logic [CODE_W-1:0]   secret [NUM_PLAYERS];
    logic [POINTS_W-1:0] score  [NUM_PLAYERS];
    logic [CODE_W-1:0]   target;
    logic [PW-1:0]       next_player;
    logic [CW-1:0]       bulls_next;
    logic [CW-1:0]       cows_next;
    logic                cow_hit;
    logic                win;

    // A legal code uses only digits up to DIGIT_MAX, each at most once.
    function automatic logic code_valid(input logic [CODE_W-1:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(code[i*DIGIT_W +: DIGIT_W]) > DIGIT_MAX) ok = 1'b0;
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (code[i*DIGIT_W +: DIGIT_W] == code[j*DIGIT_W +: DIGIT_W]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    assign enter_event = enter && !enter_q;
    assign sw_valid    = code_valid(SW);
    assign next_player = (active_player == LAST_PLAYER) ? '0 : active_player + PW'(1);
    assign target      = secret[next_player];
    assign win         = (bulls_next == CW'(NUM_DIGITS));

    // Cows only count digits that are not already bulls, so each position scores at most once.
    always_comb begin
        bulls_next = '0;
        cows_next  = '0;
        cow_hit    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cow_hit = 1'b0;
            if (guess[i*DIGIT_W +: DIGIT_W] == target[i*DIGIT_W +: DIGIT_W]) begin
                bulls_next = bulls_next + CW'(1);
            end else begin
                for (int j = 0; j < NUM_DIGITS; j++) begin
                    if (j != i && guess[i*DIGIT_W +: DIGIT_W] == target[j*DIGIT_W +: DIGIT_W])
                        cow_hit = 1'b1;
                end
                if (cow_hit) cows_next = cows_next + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= SETUP;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SETUP: if (enter_event && sw_valid && active_player == LAST_PLAYER) state_next = GUESS;
            GUESS: if (enter_event && sw_valid) state_next = CHECK;
            CHECK: state_next = win ? WIN : GUESS;
            WIN:   if (enter_event) state_next = SETUP;
            default: state_next = SETUP;
        endcase
    end

    // Datapath registers; pulses default low so each lasts a single cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            enter_q         <= 1'b0;
            active_player   <= '0;
            bull_count      <= '0;
            cow_count       <= '0;
            guess_confirmed <= 1'b0;
            input_error     <= 1'b0;
            attempt_count   <= '0;
            guess           <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                secret[p] <= '0;
                score[p]  <= '0;
            end
        end else begin
            enter_q         <= enter;
            guess_confirmed <= 1'b0;
            input_error     <= 1'b0;
            case (state)
                SETUP: begin
                    if (enter_event) begin
                        if (sw_valid) begin
                            secret[active_player] <= SW;
                            active_player         <= next_player;
                            if (active_player == LAST_PLAYER) attempt_count <= '0;
                        end else begin
                            input_error <= 1'b1;
                        end
                    end
                end
                GUESS: begin
                    if (enter_event) begin
                        if (sw_valid) guess       <= SW;
                        else          input_error <= 1'b1;
                    end
                end
                CHECK: begin
                    bull_count      <= bulls_next;
                    cow_count       <= cows_next;
                    guess_confirmed <= 1'b1;
                    if (attempt_count != 8'hFF) attempt_count <= attempt_count + 8'd1;
                    if (win) begin
                        if (score[active_player] != POINTS_MAX)
                            score[active_player] <= score[active_player] + POINTS_W'(1);
                    end else begin
                        active_player <= next_player;
                    end
                end
                WIN: begin
                    if (enter_event) begin
                        active_player <= '0;
                        bull_count    <= '0;
                        cow_count     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        game_state = state;
        points     = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            points[p*POINTS_W +: POINTS_W] = score[p];
        end
    end

endmodule

// File: tb/tb_bullcow_game_core_param.sv
// Scoreboard bench: a default-width instance and a POINTS_W=2 instance share stimulus
// so score saturation is observed alongside the normal game flow.
module tb_bullcow_game_core_param;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enter = 1'b0;
    logic [15:0] SW    = 16'h0;

    logic [2:0]  game_state1, game_state2;
    logic        active_player1, active_player2;
    logic [2:0]  bull_count1, bull_count2, cow_count1, cow_count2;
    logic        guess_confirmed1, guess_confirmed2, input_error1, input_error2;
    logic [7:0]  attempt_count1, attempt_count2;
    logic [15:0] points1;
    logic [3:0]  points2;

    bullcow_game_core_param dut1 (
        .clock(clock), .reset(reset), .enter(enter), .SW(SW),
        .game_state(game_state1), .active_player(active_player1),
        .bull_count(bull_count1), .cow_count(cow_count1),
        .guess_confirmed(guess_confirmed1), .input_error(input_error1),
        .attempt_count(attempt_count1), .points(points1)
    );

    bullcow_game_core_param #(.POINTS_W(2)) dut2 (
        .clock(clock), .reset(reset), .enter(enter), .SW(SW),
        .game_state(game_state2), .active_player(active_player2),
        .bull_count(bull_count2), .cow_count(cow_count2),
        .guess_confirmed(guess_confirmed2), .input_error(input_error2),
        .attempt_count(attempt_count2), .points(points2)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit is_err;
        int bull;
        int cow;
        int attempt;
        int ap;
        int state;
        int p0;
        int p1;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests  = 0;
    int   failed = 0;

    int          m_state, m_ap, m_attempt, m_bull, m_cow;
    int          m_score [2];
    logic [15:0] m_secret [2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    function automatic bit modelValid(input logic [15:0] code);
        logic [15:0] seen;
        logic [3:0]  d;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            d = code[i*4 +: 4];
            if (d > 4'd9) return 1'b0;
            if (seen[d]) return 1'b0;
            seen[d] = 1'b1;
        end
        return 1'b1;
    endfunction

    // Cows = digits common to both codes minus those already in place.
    task automatic modelScore(input logic [15:0] g, input logic [15:0] t, output int b, output int c);
        logic [15:0] gm, tm;
        gm = '0;
        tm = '0;
        b  = 0;
        for (int i = 0; i < 4; i++) begin
            if (g[i*4 +: 4] == t[i*4 +: 4]) b++;
            gm[g[i*4 +: 4]] = 1'b1;
            tm[t[i*4 +: 4]] = 1'b1;
        end
        c = $countones(gm & tm) - b;
    endtask

    function automatic logic [15:0] randomCode();
        logic [15:0] code;
        do begin
            for (int i = 0; i < 4; i++) code[i*4 +: 4] = 4'($urandom_range(9));
        end while (!modelValid(code));
        return code;
    endfunction

    task automatic modelReset();
        m_state = 0; m_ap = 0; m_attempt = 0; m_bull = 0; m_cow = 0;
        for (int p = 0; p < 2; p++) begin
            m_score[p]  = 0;
            m_secret[p] = '0;
        end
    endtask

    task automatic modelEvent(input logic [15:0] code);
        exp_t x;
        int   b, c;
        case (m_state)
            0: begin
                if (!modelValid(code)) begin
                    x = '{1'b1, m_bull, m_cow, m_attempt, m_ap, m_state, m_score[0], m_score[1]};
                    sb.push_back(x);
                end else begin
                    m_secret[m_ap] = code;
                    m_ap++;
                    if (m_ap == 2) begin
                        m_state = 1; m_ap = 0; m_attempt = 0;
                    end
                end
            end
            1: begin
                if (!modelValid(code)) begin
                    x = '{1'b1, m_bull, m_cow, m_attempt, m_ap, m_state, m_score[0], m_score[1]};
                    sb.push_back(x);
                end else begin
                    modelScore(code, m_secret[(m_ap + 1) % 2], b, c);
                    m_bull = b;
                    m_cow  = c;
                    if (m_attempt < 255) m_attempt++;
                    if (b == 4) begin
                        m_score[m_ap]++;
                        m_state = 3;
                    end else begin
                        m_ap = (m_ap + 1) % 2;
                    end
                    x = '{1'b0, m_bull, m_cow, m_attempt, m_ap, m_state, m_score[0], m_score[1]};
                    sb.push_back(x);
                end
            end
            3: begin
                m_state = 0; m_ap = 0; m_bull = 0; m_cow = 0;
            end
            default: ;
        endcase
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " state"}, 32'(game_state1), m_state);
        checkOutput({tag, " player"}, 32'(active_player1), m_ap);
        checkOutput({tag, " bulls"}, 32'(bull_count1), m_bull);
        checkOutput({tag, " cows"}, 32'(cow_count1), m_cow);
        checkOutput({tag, " attempts"}, 32'(attempt_count1), m_attempt);
        checkOutput({tag, " p0 score"}, 32'(points1[7:0]), m_score[0]);
        checkOutput({tag, " p1 score"}, 32'(points1[15:8]), m_score[1]);
        checkOutput({tag, " p0 score w2"}, 32'(points2[1:0]), sat3(m_score[0]));
        checkOutput({tag, " p1 score w2"}, 32'(points2[3:2]), sat3(m_score[1]));
    endtask

    task automatic applyStimulus(input string tag, input logic [15:0] code);
        modelEvent(code);
        @(negedge clock);
        SW    = code;
        enter = 1'b1;
        @(negedge clock);
        enter = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkAll(tag);
    endtask

    // Every pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (reset && (guess_confirmed1 || input_error1)) begin
            checkOutput("pulse overlap", 32'(guess_confirmed1 & input_error1), 0);
            if (sb.size() == 0) begin
                checkOutput("unexpected pulse", {31'b0, guess_confirmed1}, {31'b0, input_error1});
            end else begin
                e = sb.pop_front();
                checkOutput("pulse kind", 32'(input_error1), 32'(e.is_err));
                checkOutput("pulse kind w2", 32'(guess_confirmed2), 32'(!e.is_err));
                checkOutput("pulse state", 32'(game_state1), e.state);
                checkOutput("pulse player", 32'(active_player1), e.ap);
                if (!e.is_err) begin
                    checkOutput("pulse bulls", 32'(bull_count1), e.bull);
                    checkOutput("pulse cows", 32'(cow_count1), e.cow);
                    checkOutput("pulse attempts", 32'(attempt_count1), e.attempt);
                    checkOutput("pulse p0", 32'(points1[7:0]), e.p0);
                    checkOutput("pulse p1", 32'(points1[15:8]), e.p1);
                    checkOutput("pulse p0 w2", 32'(points2[1:0]), sat3(e.p0));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        int k;
        logic [15:0] g;

        modelReset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkAll("reset");
        checkOutput("reset confirm pulse", 32'(guess_confirmed1), 0);
        checkOutput("reset error pulse", 32'(input_error1), 0);
        reset = 1'b1;

        applyStimulus("dup digit", 16'h1123);
        applyStimulus("digit over max", 16'h12A4);
        applyStimulus("secret p0", 16'h1234);
        applyStimulus("secret p1", 16'h5678);
        applyStimulus("bad guess", 16'h1223);
        applyStimulus("guess 8765", 16'h8765);
        applyStimulus("guess 1243", 16'h1243);

        // Held enter must give exactly one check; later SW changes are ignored.
        modelEvent(16'h5670);
        @(negedge clock);
        SW     = 16'h5670;
        enter  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (guess_confirmed1) pulses++;
            if (i == 3) SW = 16'h5678;
        end
        enter = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (guess_confirmed1) pulses++;
        end
        checkOutput("held enter pulses", pulses, 1);
        checkAll("held enter");

        applyStimulus("guess 4321", 16'h4321);
        applyStimulus("winning guess", 16'h5678);
        applyStimulus("leave win", 16'h0000);

        for (int r = 0; r < 5; r++) begin
            if (m_state == 3) applyStimulus("leave win", randomCode());
            applyStimulus("round secret p0", randomCode());
            applyStimulus("round secret p1", randomCode());
            k = 0;
            while (m_state != 3 && k < 8) begin
                if (m_ap == 0) g = (r % 2 == 0) ? m_secret[1] : randomCode();
                else           g = m_secret[0];
                applyStimulus("round guess", g);
                k++;
            end
            checkOutput("round ends in win", 32'(game_state1), 3);
        end
        checkOutput("w2 p0 saturated", 32'(points2[1:0]), 3);

        // Reset while CHECK is in progress must suppress the pulse and clear everything.
        applyStimulus("leave win", 16'h0000);
        applyStimulus("secret p0", 16'h0123);
        applyStimulus("secret p1", 16'h4567);
        @(negedge clock);
        SW    = 16'h4567;
        enter = 1'b1;
        @(negedge clock);
        enter = 1'b0;
        checkOutput("in check", 32'(game_state1), 2);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst state", 32'(game_state1), 0);
        checkOutput("rst player", 32'(active_player1), 0);
        checkOutput("rst bulls", 32'(bull_count1), 0);
        checkOutput("rst cows", 32'(cow_count1), 0);
        checkOutput("rst confirm", 32'(guess_confirmed1), 0);
        checkOutput("rst error", 32'(input_error1), 0);
        checkOutput("rst attempts", 32'(attempt_count1), 0);
        checkOutput("rst points", 32'(points1), 0);
        checkOutput("rst points w2", 32'(points2), 0);
        @(negedge clock);
        checkOutput("rst no pulse", 32'(guess_confirmed1), 0);
        modelReset();
        reset = 1'b1;
        applyStimulus("after reset", 16'h9876);

        repeat (3) @(negedge clock);
        checkOutput("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
